// File: rtl/operand_issue.sv
// operand_issue: operand fetch and issue stage between decode and the
// calculation units.
//
// Accepts one decoded instruction per cycle. It reads rs1/rs2 from an
// internal register file that has NWB writeback ports, and builds the
// immediate. A per-register busy scoreboard stalls RAW/WAW hazards. The
// operand bundle is handed on through a single registered valid/ready stage.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    decoded instruction handshake
//   in_unit/in_sub_unit/in_sel/in_imm  operation class fields
//   in_instr             rd=[4:0], rs1=[12:8], rs2=[17:13], imm bits [24:5]
//   in_pc, in_jal_res    instruction PC and link value
//   out_valid/out_ready  operand bundle handshake
//   out_*                registered bundle (held while stalled downstream)
//   wb_valid/addr/data   NWB writeback ports, port i at [5i+4:5i] / [XLEN*i +: XLEN]
//   flush                drop the output bundle and clear the scoreboard
//   stall_cnt            saturating count of hazard-stall cycles
module operand_issue #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NWB  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_unit,
  input  logic [2:0]          in_sub_unit,
  input  logic [3:0]          in_sel,
  input  logic                in_imm,
  input  logic [24:0]         in_instr,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [XLEN-1:0]     in_jal_res,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:0]          out_unit,
  output logic [2:0]          out_sub_unit,
  output logic [3:0]          out_sel,
  output logic                out_imm,
  output logic [XLEN-1:0]     out_rs1,
  output logic [XLEN-1:0]     out_rs2,
  output logic [4:0]          out_rd,
  output logic [XLEN-1:0]     out_immediate,
  output logic [XLEN-1:0]     out_jal_res,
  input  logic [NWB-1:0]      wb_valid,
  input  logic [NWB*5-1:0]    wb_addr,
  input  logic [NWB*XLEN-1:0] wb_data,
  input  logic                flush,
  output logic [15:0]         stall_cnt
);

  localparam int AW = (NREG == 16) ? 4 : 5;

  // Register 0 and addresses beyond the file are hardwired zero and never busy.
  function automatic logic addr_ok(input logic [4:0] a);
    return (a != 5'd0) && ((NREG == 32) || !a[4]);
  endfunction

  function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
    logic signed [11:0] s;
    s = v;
    return XLEN'(s);
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return XLEN'(s);
  endfunction

  logic [XLEN-1:0] r_rf [NREG];
  logic [NREG-1:0] r_busy;
  logic            r_valid;
  logic [1:0]      r_unit;
  logic [2:0]      r_sub;
  logic [3:0]      r_sel;
  logic            r_imm;
  logic [XLEN-1:0] r_rs1, r_rs2, r_immv, r_jal;
  logic [4:0]      r_rd;
  logic [15:0]     r_cnt;

  logic [4:0]      w_rd, w_rs1, w_rs2;
  logic            w_pc_cls, w_lui, w_stb;
  logic            w_use_rs1, w_use_rs2, w_use_rd;
  logic            w_rs1_busy, w_rs2_busy, w_rd_busy;
  logic            w_rs1_hit, w_rs2_hit, w_rd_hit;
  logic            w_stall, w_accept;
  logic [XLEN-1:0] w_rs1_reg, w_rs2_reg, w_rs1_val, w_rs2_val, w_immv;
  logic [NREG-1:0] w_wb_hit;
  logic [XLEN-1:0] w_wb_val [NREG];
  logic            w_unused;

  assign w_unused = ^in_instr[7:5];

  assign w_rd  = in_instr[4:0];
  assign w_rs1 = in_instr[12:8];
  assign w_rs2 = in_instr[17:13];

  assign w_pc_cls  = (in_unit == 2'd0) && (in_sub_unit == 3'd0);
  assign w_lui     = in_imm && w_pc_cls && (in_sel != 4'd3);
  assign w_stb     = ((in_unit == 2'd0) || (in_unit == 2'd1)) && (in_sub_unit == 3'd1);
  assign w_use_rs1 = !w_lui;
  assign w_use_rs2 = (in_unit == 2'd0) ? ((in_sub_unit != 3'd0) && !in_imm) :
                     (in_unit == 2'd1) ? (in_sub_unit == 3'd1) : 1'b0;
  assign w_use_rd  = ((in_unit == 2'd0) || (in_unit == 2'd1)) && (in_sub_unit != 3'd1);

  // Collapse the writeback ports per register; later ports overwrite earlier
  // ones so the highest index wins for both the file and the bypass.
  always_comb begin
    w_wb_hit = '0;
    for (int r = 0; r < NREG; r++) w_wb_val[r] = '0;
    for (int p = 0; p < NWB; p++) begin
      if (wb_valid[p] && addr_ok(wb_addr[5*p +: 5])) begin
        w_wb_hit[wb_addr[5*p +: AW]] = 1'b1;
        w_wb_val[wb_addr[5*p +: AW]] = wb_data[XLEN*p +: XLEN];
      end
    end
  end

  assign w_rs1_busy = addr_ok(w_rs1) && r_busy[w_rs1[AW-1:0]];
  assign w_rs2_busy = addr_ok(w_rs2) && r_busy[w_rs2[AW-1:0]];
  assign w_rd_busy  = addr_ok(w_rd)  && r_busy[w_rd[AW-1:0]];
  assign w_rs1_hit  = addr_ok(w_rs1) && w_wb_hit[w_rs1[AW-1:0]];
  assign w_rs2_hit  = addr_ok(w_rs2) && w_wb_hit[w_rs2[AW-1:0]];
  assign w_rd_hit   = addr_ok(w_rd)  && w_wb_hit[w_rd[AW-1:0]];

  // A busy register being written this very cycle resolves the hazard.
  assign w_stall = (w_use_rs1 && w_rs1_busy && !w_rs1_hit) ||
                   (w_use_rs2 && w_rs2_busy && !w_rs2_hit) ||
                   (w_use_rd  && w_rd_busy  && !w_rd_hit);

  assign w_rs1_reg = !addr_ok(w_rs1) ? '0 :
                     (w_rs1_busy && w_rs1_hit) ? w_wb_val[w_rs1[AW-1:0]] : r_rf[w_rs1[AW-1:0]];
  assign w_rs2_reg = !addr_ok(w_rs2) ? '0 :
                     (w_rs2_busy && w_rs2_hit) ? w_wb_val[w_rs2[AW-1:0]] : r_rf[w_rs2[AW-1:0]];

  assign w_rs1_val = w_pc_cls  ? in_pc : w_rs1_reg;
  assign w_rs2_val = w_use_rs2 ? w_rs2_reg : '0;

  assign w_immv = w_lui   ? sext32({in_instr[24:5], 12'h000}) :
                  w_stb   ? sext12({in_instr[24:18], in_instr[4:0]}) :
                  in_imm  ? sext12(in_instr[24:13]) : '0;

  assign in_ready = !w_stall && (!r_valid || out_ready) && !flush;
  assign w_accept = in_valid && in_ready;

  // Register file and scoreboard: writebacks land regardless of stall/flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) r_rf[r] <= '0;
      r_busy <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (w_wb_hit[r]) r_rf[r] <= w_wb_val[r];
      end
      if (flush) begin
        r_busy <= '0;
      end else begin
        r_busy <= r_busy & ~w_wb_hit;
        // Issued after the clear so a same-cycle set takes priority.
        if (w_accept && w_use_rd && addr_ok(w_rd)) r_busy[w_rd[AW-1:0]] <= 1'b1;
      end
    end
  end

  // Output bundle stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_unit  <= '0;
      r_sub   <= '0;
      r_sel   <= '0;
      r_imm   <= 1'b0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_immv  <= '0;
      r_jal   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_unit  <= in_unit;
      r_sub   <= in_sub_unit;
      r_sel   <= in_sel;
      r_imm   <= in_imm;
      r_rs1   <= w_rs1_val;
      r_rs2   <= w_rs2_val;
      r_rd    <= w_rd;
      r_immv  <= w_immv;
      r_jal   <= in_jal_res;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (in_valid && w_stall && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign out_valid     = r_valid;
  assign out_unit      = r_unit;
  assign out_sub_unit  = r_sub;
  assign out_sel       = r_sel;
  assign out_imm       = r_imm;
  assign out_rs1       = r_rs1;
  assign out_rs2       = r_rs2;
  assign out_rd        = r_rd;
  assign out_immediate = r_immv;
  assign out_jal_res   = r_jal;
  assign stall_cnt     = r_cnt;

endmodule

// File: doc/operand_issue.md
Name: operand_issue

Overview:
- Parametrised successor to the decode-side register manager.
- Accepts one decoded instruction per cycle, reads operands from an internal register file with NWB writeback ports, and generates the sign-correct immediate.
- Tracks pending destinations in a scoreboard, stalls on RAW/WAW hazards, and bypasses same-cycle writebacks.
- Presents the operand bundle to the calculation units through a registered valid/ready stage.

Parameters:
- XLEN, 32, datapath width.
- NREG, 32, architectural registers; legal values 16 or 32.
- NWB, 2, number of writeback ports, 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decoded instruction valid.
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready.
- in_unit  in  2  unit select.
- in_sub_unit  in  3  sub-unit select.
- in_sel  in  4  operation select.
- in_imm  in  1  immediate form.
- in_instr  in  25  packed fields: rd=[4:0], rs1=[12:8], rs2=[17:13], imm bits [24:5].
- in_pc  in  XLEN  instruction PC.
- in_jal_res  in  XLEN  link value, passed through.
- out_valid  out  1  bundle valid.
- out_ready  in  1  consumer accepts.
- out_unit, out_sub_unit, out_sel, out_imm  out  2/3/4/1  registered copies of the inputs.
- out_rs1, out_rs2  out  XLEN  operands.
- out_rd  out  5  destination register.
- out_immediate  out  XLEN  generated immediate.
- out_jal_res  out  XLEN  passed through.
- wb_valid  in  NWB  writeback strobes.
- wb_addr  in  NWB*5  writeback addresses, port i at [5i+4:5i].
- wb_data  in  NWB*XLEN  writeback data.
- flush  in  1  pipeline flush.
- stall_cnt  out  16  count of hazard-stall cycles.

Behaviour:
- Reset (rst high, asynchronous): out_valid=0, all out_* = 0, register file = 0, scoreboard clear, stall_cnt=0.
- Operand usage:
  - PC-class instruction: unit=0, sub=0.
  - lui = in_imm && unit=0 && sub=0 && sel!=3.
  - rs1 used = !lui.
  - rs2 used:
    - unit=0: sub!=0 && !in_imm.
    - unit=1: sub=1.
    - otherwise: 0.
  - rd used = (unit=0 && sub!=1) || (unit=1 && sub!=1).
- rs1 value:
  - PC-class: rs1 = in_pc.
  - Unused rs2: rs2 = 0.
  - Register 0 and any address >= NREG: read as 0, are never busy, and writes to them are ignored.
- Immediate:
  - lui: {instr[24:5], 12'h0}.
  - Store/branch (unit in {0,1} and sub=1): sign-extended {instr[24:18], instr[4:0]}.
  - Other in_imm: sign-extended instr[24:13].
  - !in_imm: 0.
- Scoreboard: one busy bit per register.
  - Stall condition: any used source, or the used rd, is busy and is not written by a valid wb port in the same cycle.
  - in_ready = !stall && (!out_valid || out_ready) && !flush.
- Bypass: a used source that is busy and written this cycle takes the wb data, not the stale file value.
  - Several wb ports to the same address in one cycle: the highest index wins, for both the file and the bypass.
- Accept:
  - Latency is 1 cycle: the bundle is registered at the accepting edge and out_valid rises the next cycle.
  - If rd is used and rd != 0, busy[rd] is set.
  - Set and clear of the same register in one cycle: set wins.
- Output hold: while out_valid && !out_ready, all out_* stay stable.
  - An accept can occur in the same cycle as an output handshake (full throughput).
- Writeback: the file is written at the clock edge; writes proceed regardless of stall or flush.
- flush:
  - Next edge: out_valid=0 and the scoreboard clears.
  - No instruction is accepted that cycle.
  - A flush during reset is ignored.
- stall_cnt: increments each cycle that in_valid && stall; saturates at 16'hFFFF.

Test Plan:
- Reset, write x5=0x1234 via wb0, issue add x1,x5,x5 (unit0 sub2) -> out_rs1 = out_rs2 = 0x1234, out_valid one cycle after accept, busy[1] set.
- Issue x1 producer, then a consumer of x1 with no wb -> in_ready=0 and stall_cnt counts 3 over 3 cycles. wb1 writes x1=0xAA -> accepted that cycle with out_rs1=0xAA (bypass).
- wb0 and wb1 both write x7 (0x1, 0x2) in the same cycle -> a later read of x7 returns 0x2.
- Store, instr[24:18]=7'h7F, instr[4:0]=5'h1F -> out_immediate=0xFFFFFFFF. lui with instr[24:5]=20'h12345 -> 0x12345000, rs1 unused. PC-class -> out_rs1=in_pc.
- Hold out_ready=0 for 4 cycles with in_valid high -> outputs stable, in_ready=0. Release -> back-to-back bundles with one per cycle.
- Busy x3, assert flush -> out_valid=0 next cycle, busy clear, a consumer of x3 is accepted immediately. Assert rst mid-stall -> all outputs 0 asynchronously.
